// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative mult/div sequencer owning HI/LO, with EX-stage stall
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t      state;
  logic [63:0] acc;
  logic [31:0] operand;
  logic [4:0]  count;
  logic        isDiv, divZero, negQ, negR;

  logic        accept, signedOp;
  logic [31:0] magA, magB;
  logic [32:0] sum33, remShift;
  logic [31:0] remDiff;
  logic        remGe;
  logic [63:0] mulNext, divNext, accNeg;

  assign busy     = (state != IDLE);
  assign stall    = op_valid & ~flush & busy;
  assign rd_data  = (op == 3'd4) ? hi : lo;
  assign accept   = op_valid & ~flush & ~busy;
  assign signedOp = (op == 3'd0) | (op == 3'd2);
  assign magA     = (signedOp && src_a[31]) ? -src_a : src_a;
  assign magB     = (signedOp && src_b[31]) ? -src_b : src_b;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign sum33    = {1'b0, acc[63:32]} + {1'b0, operand};
  assign mulNext  = acc[0] ? {sum33, acc[31:1]} : {1'b0, acc[63:1]};

  // Divide: acc = {remainder, quotient}; shifted remainder needs 33 bits for large divisors
  assign remShift = acc[63:31];
  assign remGe    = (remShift >= {1'b0, operand});
  assign remDiff  = remShift[31:0] - operand;
  assign divNext  = remGe ? {remDiff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

  assign accNeg   = ~acc + 64'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= 64'd0;
      operand <= 32'd0;
      count   <= 5'd0;
      isDiv   <= 1'b0;
      divZero <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                if (op[1] && src_b == 32'd0) begin
                  hi      <= src_a;
                  lo      <= 32'hFFFF_FFFF;
                  isDiv   <= 1'b1;
                  divZero <= 1'b1;
                  state   <= SIGN;
                end else begin
                  acc     <= op[1] ? {32'd0, magA} : {32'd0, magB};
                  operand <= op[1] ? magB : magA;
                  negQ    <= signedOp & (src_a[31] ^ src_b[31]);
                  negR    <= signedOp & src_a[31];
                  isDiv   <= op[1];
                  divZero <= 1'b0;
                  count   <= 5'd0;
                  state   <= CALC;
                end
              end
              3'd6:    hi <= src_a;
              3'd7:    lo <= src_a;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc   <= isDiv ? divNext : mulNext;
          count <= count + 5'd1;
          if (count == 5'd31) state <= SIGN;
        end
        SIGN: begin
          if (!divZero) begin
            if (isDiv) begin
              lo <= negQ ? -acc[31:0] : acc[31:0];
              hi <= negR ? -acc[63:32] : acc[63:32];
            end else begin
              {hi, lo} <= negQ ? accNeg : acc;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, op_valid, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall, busy;
  logic [31:0] rd_data, hi, lo;

  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .flush(flush),
    .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy),
    .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int   nTests = 0;
  int   nFail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every falling edge of busy completes one scoreboard entry
  int   busyCnt  = 0;
  logic prevBusy = 1'b0;
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busyCnt++;
    end else if (prevBusy) begin
      if (expQ.size() == 0) begin
        nTests++;
        nFail++;
        $display("FAIL unexpected_completion: busy fell with empty scoreboard");
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("sb_hi", hi, e.hi);
        check("sb_lo", lo, e.lo);
        check("sb_busy_cycles", 32'(busyCnt), 32'(e.cyc));
      end
      busyCnt = 0;
    end
    prevBusy = (busy === 1'b1);
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eHi, input logic [31:0] eLo, input int eCyc);
    exp_t e;
    e.hi = eHi; e.lo = eLo; e.cyc = eCyc;
    expQ.push_back(e);
    op = o; src_a = a; src_b = b; op_valid = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      nTests++;
      nFail++;
      $display("FAIL wait_idle_timeout: busy=%b after %0d cycles", busy, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; op_valid = 1'b0; flush = 1'b0; op = 3'd0; src_a = 0; src_b = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(posedge clk); #1;

    // mult -3 x 7, then mflo / mfhi
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    waitIdle();
    op = 3'd5; op_valid = 1'b1; #1;
    check("mflo_rd", rd_data, 32'hFFFF_FFEB);
    op = 3'd4; #1;
    check("mfhi_rd", rd_data, 32'hFFFF_FFFF);
    op_valid = 1'b0;
    @(posedge clk); #1;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    waitIdle();
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    waitIdle();
    issue(3'd3, 32'h64, 32'd0, 32'h64, 32'hFFFF_FFFF, 1);
    waitIdle();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    waitIdle();

    // mfhi right behind a multu: stalls for the whole op, then reads the new HI
    issue(3'd1, 32'h0001_0000, 32'h0003_0000, 32'd3, 32'd0, 33);
    op = 3'd4; op_valid = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (stall === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("stall_cycles", 32'(cnt), 32'd33);
    check("stall_release_rd", rd_data, 32'd3);
    op_valid = 1'b0;
    @(posedge clk); #1;

    // flush masks stall while busy
    issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    op = 3'd4; op_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 32'(stall), 32'd0);
    flush = 1'b0;
    @(negedge clk);
    check("noflush_stall", 32'(stall), 32'd1);
    op_valid = 1'b0;
    waitIdle();

    // mthi write at the accept edge
    op = 3'd6; src_a = 32'hABCD; op_valid = 1'b1;
    @(posedge clk); #1 op_valid = 1'b0;
    check("mthi_hi", hi, 32'hABCD);
    check("mthi_busy", 32'(busy), 32'd0);

    // reset at cycle 10 of a divide abandons it and clears HI/LO
    issue(3'd2, 32'd1000, 32'd3, 32'd0, 32'd0, 10);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    @(posedge clk); #1;
    op = 3'd7; src_a = 32'h1234; op_valid = 1'b1;
    @(posedge clk); #1 op_valid = 1'b0;
    check("mtlo_lo", lo, 32'h1234);
    repeat (2) @(posedge clk);

    check("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
